trig_engine: RTL and testbench
==============================

# trig_engine

Parametrised multi-channel trigger engine for the acquisition front end. It is the successor to the fixed 2-analog/2-digital sync block. It qualifies edge, level and pulse-width trigger conditions on N analog and M digital channels, and adds hysteresis as a parameter, an Arm/holdoff/trigger state machine, and saturating width counters. Start feeds the capture controller; optional per-channel edge/time measurement feeds the register bank.

## Interface
- N_ACH, 2, number of analog channels
- N_DCH, 2, number of digital channels
- DW, 8, analog sample width
- TW, 16, width/holdoff counter width
- HYST, 12, edge hysteresis in LSB
- Mclk  in  1  main clock
- Reset  in  1  asynchronous, active-high
- Trig_Mode  in  8  [7:3] channel index (analog first, then digital), [2:0] condition
- Vthreshold  in  DW  analog trigger level
- Tthreshold  in  TW  pulse-width threshold, in Mclk cycles
- Holdoff  in  TW  cycles ignored after Arm
- Din  in  N_ACH*DW+N_DCH  analog channel i at [i*DW+:DW]; digital j at bit N_ACH*DW+j
- Sampled  in  1  pre-trigger buffer filled; qualifies all triggers
- Arm  in  1  one-cycle pulse; (re)starts a trigger cycle
- Start  out  1  sync start, held high until next Arm or Reset
- Busy  out  1  high in HOLD or ARMED
- Meas_Edge, Meas_TL, Meas_TH  out  (N_ACH+N_DCH)*16  per-channel edge count, low-time sum, high-time sum

## Operation
- Channel flag (analog): set when Din > Vthreshold+HYST; cleared when Din < Vthreshold−HYST.
  - Thresholds computed at DW+1 bits and clamped to [0, 2^DW−1].
  - Strict compares, so a clamped threshold can never be crossed.
- Channel flag (digital): the registered input bit.
- rise/fall: single-cycle strobes when the flag changes.
- Width counter:
  - Clears to 0 on each flag change; otherwise increments, saturating at 2^TW−1 (never wraps).
  - On rise, the ending low pulse is classified short (cnt < Tthreshold) or long (>=).
  - On fall, the ending high pulse is classified the same way.
- Conditions [2:0]:
  - 0 fall, 1 rise, 2 flag low, 3 flag high.
  - 4 short low, 5 long low, 6 short high, 7 long high.
- Channel index >= N_ACH+N_DCH: auto mode; the condition is always true.
- States:
  - IDLE: reset state.
  - Arm -> HOLD, with holdoff count = 0.
  - HOLD: increments each cycle; when count == Holdoff -> ARMED. Holdoff=0 gives one HOLD cycle.
  - ARMED: when the condition is true AND Sampled=1 -> TRIG.
  - TRIG: Start=1. Arm -> HOLD.
- Arm in any state restarts HOLD, clears Start and clears the holdoff count. Channel flags and width counters are not cleared.
- Trig_Mode change in ARMED takes effect on the next cycle; no spurious Start.
- Condition true while Sampled=0: ignored; no latching for later.

## Timing
- Reset values: Start=0, Busy=0, state IDLE, flags 0, counters 0, all Meas_* 0.
- Din crossing presented at edge k: flag updates at k; rise/fall valid during cycle k..k+1; Start=1 after edge k+1 (latency 2).
- Level modes: Start 1 cycle after entering ARMED if the level already holds.
- Arm at edge k: Start=0 and Busy=1 after k.
- Arm coinciding with a trigger condition: Arm wins.
- Reset mid-operation: immediate return to reset values.

## Configuration
- TRIG_MEAS_EN defined: per channel, 16-bit wrapping Edge (+1 per flag change) and TL/TH (+= width count at rise/fall) accumulators. All accumulators clear on Reset and on Arm.
- TRIG_MEAS_EN undefined: no accumulators; Meas_* tied to 0.

## Structure
- trig_pkg: condition codes, state enum (IDLE/HOLD/ARMED/TRIG), measurement width 16.
- Sub-module trig_chan: one per channel via generate. It holds the flag, edge strobes, saturating width counter, short/long classification and optional measurement.
- trig_engine: the state machine and the Trig_Mode mux.

## Test plan
- A0 rise, defaults, Vthreshold=100: Din ramp 80→120, Arm, Holdoff=0, Sampled=1 -> Start=1 two edges after Din=113 is applied; 112 does not trigger.
- Holdoff=10, mode 0x09 (ch1 rise), edge 5 cycles after Arm -> no Start; edge 15 cycles after Arm -> Start.
- Digital ch2 (mode 0x15 long low), Tthreshold=4: low pulses of 3 and 4 cycles -> Start only after the 4-cycle pulse ends.
- Width saturation, TW=4: 40-cycle low then rise, Tthreshold=15 -> classified long, no wrap to short.
- Vthreshold=250, HYST=12: upper threshold clamps to 255 -> rise never fires, no Start; Sampled=0 during edge -> no Start.
- TRIG_MEAS_EN: 3 full periods of 5 low/7 high on ch2 -> Meas_Edge=6, TL=15, TH=21; Arm -> all zero.

Source files
------------

// File: rtl/trig_pkg.sv
// trig_pkg: condition codes, FSM state encoding and measurement width shared by trig_engine
package trig_pkg;

    localparam int MW = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;
    localparam logic [1:0] ST_TRIG  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        HOLD  = ST_HOLD,
        ARMED = ST_ARMED,
        TRIG  = ST_TRIG
    } state_t;

    typedef enum logic [2:0] {
        C_FALL       = 3'd0,
        C_RISE       = 3'd1,
        C_LOW        = 3'd2,
        C_HIGH       = 3'd3,
        C_SHORT_LOW  = 3'd4,
        C_LONG_LOW   = 3'd5,
        C_SHORT_HIGH = 3'd6,
        C_LONG_HIGH  = 3'd7
    } cond_t;

endpackage

// File: rtl/trig_chan.sv
// trig_chan: one channel's flag (hysteresis for analog), edge strobes, saturating width
// counter and short/long pulse classification; TRIG_MEAS_EN adds edge/time accumulators.
module trig_chan
    import trig_pkg::*;
#(
    parameter int DW     = 8,
    parameter int TW     = 16,
    parameter int HYST   = 12,
    parameter bit ANALOG = 1'b1
) (
    input  logic          Mclk,
    input  logic          Reset,
`ifdef TRIG_MEAS_EN
    input  logic          i_arm,
    output logic [MW-1:0] o_edge,
    output logic [MW-1:0] o_tl,
    output logic [MW-1:0] o_th,
`endif
    input  logic [DW-1:0] i_din,
    input  logic [DW-1:0] i_vth,
    input  logic [TW-1:0] i_tth,
    output logic [7:0]    o_ev
);

    logic [DW:0]   w_hi_raw;
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_lo;
    logic          w_nflag;
    logic          w_chg;
    logic [TW-1:0] w_inc;
    logic          r_flag;
    logic          r_rise;
    logic          r_fall;
    logic          r_long;
    logic [TW-1:0] r_cnt;

    // Thresholds clamp to the sample range, so a clamped level can never be crossed
    assign w_hi_raw = {1'b0, i_vth} + (DW+1)'(HYST);
    assign w_hi     = w_hi_raw[DW] ? '1 : w_hi_raw[DW-1:0];
    assign w_lo     = (i_vth < DW'(HYST)) ? '0 : i_vth - DW'(HYST);
    assign w_nflag  = !ANALOG ? i_din[0] :
                      (i_din > w_hi) ? 1'b1 :
                      (i_din < w_lo) ? 1'b0 : r_flag;
    assign w_chg    = w_nflag ^ r_flag;
    // Width including the current cycle; sticks at all-ones instead of wrapping
    assign w_inc    = &r_cnt ? r_cnt : r_cnt + TW'(1);

    // Flag, strobes, classification and width counter all update on the edge the flag changes
    always_ff @(posedge Mclk or posedge Reset) begin
        if (Reset) begin
            r_flag <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_long <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_flag <= w_nflag;
            r_rise <= w_chg & w_nflag;
            r_fall <= w_chg & ~w_nflag;
            r_long <= w_inc >= i_tth;
            r_cnt  <= w_chg ? '0 : w_inc;
        end
    end

    assign o_ev[C_FALL]       = r_fall;
    assign o_ev[C_RISE]       = r_rise;
    assign o_ev[C_LOW]        = ~r_flag;
    assign o_ev[C_HIGH]       = r_flag;
    assign o_ev[C_SHORT_LOW]  = r_rise & ~r_long;
    assign o_ev[C_LONG_LOW]   = r_rise & r_long;
    assign o_ev[C_SHORT_HIGH] = r_fall & ~r_long;
    assign o_ev[C_LONG_HIGH]  = r_fall & r_long;

`ifdef TRIG_MEAS_EN
    logic [MW-1:0] r_edge;
    logic [MW-1:0] r_tl;
    logic [MW-1:0] r_th;

    // Wrapping accumulators; the ending pulse width is added on the edge that ends it
    always_ff @(posedge Mclk or posedge Reset) begin
        if (Reset) begin
            r_edge <= '0;
            r_tl   <= '0;
            r_th   <= '0;
        end else if (i_arm) begin
            r_edge <= '0;
            r_tl   <= '0;
            r_th   <= '0;
        end else begin
            r_edge <= r_edge + MW'(w_chg);
            if (w_chg && w_nflag) r_tl <= r_tl + MW'(w_inc);
            if (w_chg && !w_nflag) r_th <= r_th + MW'(w_inc);
        end
    end

    assign o_edge = r_edge;
    assign o_tl   = r_tl;
    assign o_th   = r_th;
`endif

endmodule

// File: rtl/trig_engine.sv
// trig_engine: multi-channel trigger qualifier with Arm/holdoff/trigger state machine.
// Define TRIG_MEAS_EN to enable per-channel edge count and low/high time accumulators.
module trig_engine
    import trig_pkg::*;
#(
    parameter int N_ACH = 2,
    parameter int N_DCH = 2,
    parameter int DW    = 8,
    parameter int TW    = 16,
    parameter int HYST  = 12
) (
    input  logic                          Mclk,
    input  logic                          Reset,
    input  logic [7:0]                    Trig_Mode,
    input  logic [DW-1:0]                 Vthreshold,
    input  logic [TW-1:0]                 Tthreshold,
    input  logic [TW-1:0]                 Holdoff,
    input  logic [N_ACH*DW+N_DCH-1:0]     Din,
    input  logic                          Sampled,
    input  logic                          Arm,
    output logic                          Start,
    output logic                          Busy,
    output logic [(N_ACH+N_DCH)*MW-1:0]   Meas_Edge,
    output logic [(N_ACH+N_DCH)*MW-1:0]   Meas_TL,
    output logic [(N_ACH+N_DCH)*MW-1:0]   Meas_TH
);

    localparam int NCH = N_ACH + N_DCH;

    logic [7:0]    w_ev [NCH];
    cond_t         w_code;
    logic          w_cond;
    state_t        r_state;
    logic [TW-1:0] r_hcnt;

    genvar c;
    for (c = 0; c < NCH; c = c + 1) begin : g_ch
        logic [DW-1:0] w_din;
        if (c < N_ACH) begin : g_a
            assign w_din = Din[c*DW +: DW];
        end else begin : g_d
            assign w_din = DW'(Din[N_ACH*DW + c - N_ACH]);
        end
        trig_chan #(
            .DW     (DW),
            .TW     (TW),
            .HYST   (HYST),
            .ANALOG (c < N_ACH)
        ) u_chan (
            .Mclk   (Mclk),
            .Reset  (Reset),
`ifdef TRIG_MEAS_EN
            .i_arm  (Arm),
            .o_edge (Meas_Edge[c*MW +: MW]),
            .o_tl   (Meas_TL[c*MW +: MW]),
            .o_th   (Meas_TH[c*MW +: MW]),
`endif
            .i_din  (w_din),
            .i_vth  (Vthreshold),
            .i_tth  (Tthreshold),
            .o_ev   (w_ev[c])
        );
    end

`ifndef TRIG_MEAS_EN
    assign Meas_Edge = '0;
    assign Meas_TL   = '0;
    assign Meas_TH   = '0;
`endif

    assign w_code = cond_t'(Trig_Mode[2:0]);

    // Selected channel's condition; an index past the last channel is auto mode (always true)
    always_comb begin
        w_cond = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (Trig_Mode[7:3] == 5'(i)) w_cond = w_ev[i][w_code];
    end

    // Arm restarts holdoff from any state and wins over a coincident trigger
    always_ff @(posedge Mclk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_hcnt  <= '0;
        end else if (Arm) begin
            r_state <= HOLD;
            r_hcnt  <= '0;
        end else if (r_state == HOLD) begin
            if (r_hcnt == Holdoff) r_state <= ARMED;
            r_hcnt <= r_hcnt + TW'(1);
        end else if (r_state == ARMED && w_cond && Sampled) begin
            r_state <= TRIG;
        end
    end

    assign Start = r_state == TRIG;
    assign Busy  = r_state == HOLD || r_state == ARMED;

endmodule

// File: tb/tb_trig_engine.sv
// tb_trig_engine: vector table plus multi-cycle sequences for trig_engine (default and TW=4)
module tb_trig_engine;

    logic        Mclk = 1'b0;
    logic        Reset = 1'b1;
    logic        Arm = 1'b0;
    logic        Sampled = 1'b0;
    logic [7:0]  Trig_Mode = 8'h01;
    logic [7:0]  Vthreshold = 8'd100;
    logic [7:0]  a0 = 8'd80;
    logic [7:0]  a1 = 8'd80;
    logic [1:0]  dg = 2'b00;
    logic [15:0] Tthreshold = 16'd4;
    logic [15:0] Holdoff = 16'd0;
    logic [17:0] Din;
    logic        Start, Busy, s_start, s_busy;
    logic [63:0] Meas_Edge, Meas_TL, Meas_TH, s_edge, s_tl, s_th;
    int          n_vec = 0;
    int          n_bad = 0;

`ifdef TRIG_MEAS_EN
    localparam logic [15:0] E_EDGE = 16'd6, E_TL = 16'd15, E_TH = 16'd21;
`else
    localparam logic [15:0] E_EDGE = 16'd0, E_TL = 16'd0, E_TH = 16'd0;
`endif

    typedef struct {
        logic [7:0] mode;
        logic [7:0] vth;
        logic [7:0] a0;
        logic       arm;
        logic       smp;
        logic       st;
        logic       bz;
    } vec_t;
    vec_t tbl[$];

    assign Din = {dg, a1, a0};
    always #5 Mclk = ~Mclk;

    trig_engine u_dut (
        .Mclk(Mclk), .Reset(Reset), .Trig_Mode(Trig_Mode), .Vthreshold(Vthreshold),
        .Tthreshold(Tthreshold), .Holdoff(Holdoff), .Din(Din), .Sampled(Sampled), .Arm(Arm),
        .Start(Start), .Busy(Busy), .Meas_Edge(Meas_Edge), .Meas_TL(Meas_TL), .Meas_TH(Meas_TH)
    );

    trig_engine #(.TW(4)) u_sat (
        .Mclk(Mclk), .Reset(Reset), .Trig_Mode(Trig_Mode), .Vthreshold(Vthreshold),
        .Tthreshold(Tthreshold[3:0]), .Holdoff(Holdoff[3:0]), .Din(Din), .Sampled(Sampled),
        .Arm(Arm), .Start(s_start), .Busy(s_busy), .Meas_Edge(s_edge), .Meas_TL(s_tl),
        .Meas_TH(s_th)
    );

    task automatic tick();
        @(posedge Mclk);
        @(negedge Mclk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] m, input logic [7:0] v, input logic [7:0] a,
                       input logic ar, input logic sm, input logic st, input logic bz);
        tbl.push_back('{m, v, a, ar, sm, st, bz});
    endtask

    initial begin
        logic [13:0] pat;
        // mode, vth, a0, arm, sampled, exp Start, exp Busy (each row is one clock edge)
        add(8'h01, 8'd100, 8'd80,  1, 1, 0, 1);
        add(8'h01, 8'd100, 8'd90,  0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd100, 0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd112, 0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd113, 0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd120, 0, 1, 1, 0);
        add(8'h01, 8'd100, 8'd120, 0, 1, 1, 0);
        add(8'h01, 8'd100, 8'd80,  0, 1, 1, 0);
        add(8'h01, 8'd100, 8'd80,  1, 1, 0, 1);
        add(8'h01, 8'd100, 8'd80,  0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd120, 0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd120, 1, 1, 0, 1);
        add(8'h01, 8'd100, 8'd120, 0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd120, 0, 1, 0, 1);
        add(8'h03, 8'd100, 8'd120, 0, 1, 1, 0);
        add(8'h03, 8'd100, 8'd120, 1, 0, 0, 1);
        add(8'h03, 8'd100, 8'd120, 0, 0, 0, 1);
        add(8'h03, 8'd100, 8'd120, 0, 0, 0, 1);
        add(8'h03, 8'd100, 8'd120, 0, 1, 1, 0);
        add(8'h01, 8'd100, 8'd80,  1, 1, 0, 1);
        add(8'h01, 8'd100, 8'd80,  0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd120, 0, 0, 0, 1);
        add(8'h01, 8'd100, 8'd120, 0, 0, 0, 1);
        add(8'h01, 8'd100, 8'd120, 0, 1, 0, 1);
        add(8'h01, 8'd100, 8'd120, 0, 1, 0, 1);
        add(8'hF8, 8'd100, 8'd80,  1, 1, 0, 1);
        add(8'hF8, 8'd100, 8'd80,  0, 1, 0, 1);
        add(8'hF8, 8'd100, 8'd80,  0, 1, 1, 0);
        add(8'h01, 8'd250, 8'd0,   1, 1, 0, 1);
        add(8'h01, 8'd250, 8'd0,   0, 1, 0, 1);
        add(8'h01, 8'd250, 8'd255, 0, 1, 0, 1);
        add(8'h01, 8'd250, 8'd255, 0, 1, 0, 1);
        add(8'h01, 8'd250, 8'd255, 0, 1, 0, 1);

        repeat (2) @(negedge Mclk);
        chk("rst_start", Start, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_meas_edge", Meas_Edge, 0);
        chk("rst_meas_tl", Meas_TL, 0);
        chk("rst_meas_th", Meas_TH, 0);
        chk("rst_sat_start", s_start, 0);
        Reset = 1'b0;
        Sampled = 1'b1;

        foreach (tbl[i]) begin
            Trig_Mode  = tbl[i].mode;
            Vthreshold = tbl[i].vth;
            a0         = tbl[i].a0;
            Arm        = tbl[i].arm;
            Sampled    = tbl[i].smp;
            tick();
            chk($sformatf("vec%0d_start", i), Start, tbl[i].st);
            chk($sformatf("vec%0d_busy", i), Busy, tbl[i].bz);
        end
        Arm = 1'b0;
        Sampled = 1'b1;
        Vthreshold = 8'd100;
        a0 = 8'd80;

        // Asynchronous reset from TRIG
        Trig_Mode = 8'hF8;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        tick();
        tick();
        chk("pre_reset_start", Start, 1);
        Reset = 1'b1;
        #1;
        chk("async_rst_start", Start, 0);
        chk("async_rst_busy", Busy, 0);
        @(negedge Mclk);
        Reset = 1'b0;

        // Holdoff=10 on ch1 rise: edge at +5 ignored, edge at +15 triggers
        Holdoff = 16'd10;
        Trig_Mode = 8'h09;
        for (int t = 0; t <= 20; t++) begin
            Arm = (t == 0);
            a1 = ((t >= 5 && t < 8) || t >= 15) ? 8'd120 : 8'd80;
            tick();
            chk($sformatf("holdoff_t%0d_start", t), Start, t >= 16);
            chk($sformatf("holdoff_t%0d_busy", t), Busy, t < 16);
        end
        Arm = 1'b0;
        a1 = 8'd80;

        // Digital ch2 long low, Tthreshold=4: 3-cycle low is short, 4-cycle low triggers
        Holdoff = 16'd0;
        Trig_Mode = 8'h15;
        Tthreshold = 16'd4;
        dg = 2'b01;
        tick();
        tick();
        pat = 14'b11100001100011;
        for (int t = 0; t <= 13; t++) begin
            Arm = (t == 0);
            dg[0] = pat[t];
            tick();
            chk($sformatf("dlong_t%0d_start", t), Start, t >= 12);
        end
        Arm = 1'b0;

        // 40-cycle low with Tthreshold=15: the TW=4 counter saturates and still reads long
        Tthreshold = 16'd15;
        dg[0] = 1'b1;
        tick();
        for (int t = 0; t <= 42; t++) begin
            Arm = (t == 0);
            dg[0] = (t >= 1 && t <= 40) ? 1'b0 : 1'b1;
            tick();
            if (t >= 40) begin
                chk($sformatf("sat_t%0d_start", t), s_start, t >= 42);
                chk($sformatf("wide_t%0d_start", t), Start, t >= 42);
            end
        end
        Arm = 1'b0;

        // Three periods of 5 low / 7 high on ch2; Arm coincides with the first fall
        tick();
        Arm = 1'b1;
        dg[0] = 1'b0;
        tick();
        Arm = 1'b0;
        repeat (4) tick();
        for (int p = 0; p < 3; p++) begin
            dg[0] = 1'b1;
            repeat (7) tick();
            dg[0] = 1'b0;
            repeat (5) tick();
        end
        chk("meas_edge_ch2", Meas_Edge[47:32], E_EDGE);
        chk("meas_tl_ch2", Meas_TL[47:32], E_TL);
        chk("meas_th_ch2", Meas_TH[47:32], E_TH);
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        chk("meas_edge_arm_clr", Meas_Edge, 0);
        chk("meas_tl_arm_clr", Meas_TL, 0);
        chk("meas_th_arm_clr", Meas_TH, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
